// File: rtl/exmem_stage_pkg.sv
// -----------------------------------------------------------------------------
// exmem_stage_pkg
// Shared pipeline definitions for the EX/MEM register (and the ID/EX register,
// which uses the same 22-bit control word bit map).
//   - control-word bit indices
//   - mem_size encodings plus a decode helper that folds the reserved code
//   - the packed record held by the EX/MEM stage register
// -----------------------------------------------------------------------------
package exmem_stage_pkg;

    localparam int CTRL_W           = 22;

    // Control-word bit map
    localparam int CTRL_MEM_EN      = 21;
    localparam int CTRL_MEM_RW      = 20;  // 1 = write
    localparam int CTRL_SIZE_HI     = 19;
    localparam int CTRL_SIZE_LO     = 18;
    localparam int CTRL_LOAD        = 10;
    localparam int CTRL_RF_EN       = 9;
    localparam int CTRL_LOAD_SIGNED = 7;
    localparam int CTRL_HI_WE       = 2;
    localparam int CTRL_LO_WE       = 1;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10,
        MEM_SIZE_RSVD = 2'b11
    } mem_size_e;

    // The reserved size code is treated as a full word access.
    function automatic mem_size_e decode_mem_size(input logic [1:0] code);
        mem_size_e size;
        size = mem_size_e'(code);
        if (size == MEM_SIZE_RSVD) begin
            size = MEM_SIZE_WORD;
        end
        return size;
    endfunction

    // Everything the EX/MEM register holds, raw and decoded.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       alu_out;
        logic [31:0]       store_data;
        logic [4:0]        dest;
        logic [8:0]        pc8;
        logic              valid;
        logic              load_instr;
        logic              rf_enable;
        logic              mem_enable;
        logic              mem_rw;
        logic [1:0]        mem_size;
        logic              load_signed;
    } exmem_regs_t;

endpackage

// File: rtl/hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// HI and LO 32-bit special registers for the EX/MEM stage. Only instantiated
// when EXMEM_HILO_EN is defined.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (clears both)
//   hi_we, lo_we    : write enables (already qualified by the caller)
//   wdata           : value written to whichever register is enabled
//   hi, lo          : current register contents
// -----------------------------------------------------------------------------
module hilo_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (hi_we) begin
                hi_reg <= wdata;
            end
            if (lo_we) begin
                lo_reg <= wdata;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/exmem_stage.sv
// -----------------------------------------------------------------------------
// exmem_stage
// EX/MEM pipeline register. Captures the EX-stage control word and data with
// one cycle of latency and also registers the decoded memory/register-file
// controls the MEM stage needs.
// Priority per edge: reset > flush > stall > load.
//   flush : load a bubble (everything zero, MEM_valid = 0)
//   stall : hold all registers
// Optional feature: define EXMEM_HILO_EN to add HI/LO registers (hilo_reg)
// and the MEM_hi / MEM_lo outputs.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   stall, flush               : pipeline control
//   EX_control_signals [21:0]  : control word from EX
//   EX_alu_out, EX_store_data  : ALU result / address, store data
//   EX_dest [4:0], EX_PC8 [8:0]: destination register, link address
//   EX_valid                   : EX holds a real instruction
//   MEM_*                      : registered copies and decoded controls
//   MEM_hi, MEM_lo             : HI/LO contents (EXMEM_HILO_EN only)
// -----------------------------------------------------------------------------
module exmem_stage
    import exmem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [CTRL_W-1:0] EX_control_signals,
    input  logic [31:0]       EX_alu_out,
    input  logic [31:0]       EX_store_data,
    input  logic [4:0]        EX_dest,
    input  logic [8:0]        EX_PC8,
    input  logic              EX_valid,
    output logic [CTRL_W-1:0] MEM_control_signals,
    output logic [31:0]       MEM_alu_out,
    output logic [31:0]       MEM_store_data,
    output logic [4:0]        MEM_dest,
    output logic [8:0]        MEM_PC8,
    output logic              MEM_valid,
    output logic              MEM_load_instr,
    output logic              MEM_rf_enable,
    output logic              MEM_mem_enable,
    output logic              MEM_mem_rw,
    output logic [1:0]        MEM_mem_size,
    output logic              MEM_load_signed
`ifdef EXMEM_HILO_EN
   ,output logic [31:0]       MEM_hi,
    output logic [31:0]       MEM_lo
`endif
);

    exmem_regs_t stage_reg;
    exmem_regs_t stage_next;

    // Decode happens before the register so the MEM stage sees clean,
    // registered enables derived from exactly the control word captured.
    always_comb begin
        stage_next             = '0;
        stage_next.ctrl        = EX_control_signals;
        stage_next.alu_out     = EX_alu_out;
        stage_next.store_data  = EX_store_data;
        stage_next.dest        = EX_dest;
        stage_next.pc8         = EX_PC8;
        stage_next.valid       = EX_valid;
        // Side-effecting enables are killed for a non-instruction.
        stage_next.load_instr  = EX_valid & EX_control_signals[CTRL_LOAD];
        stage_next.mem_enable  = EX_valid & EX_control_signals[CTRL_MEM_EN];
        // r0 is hard-wired zero, so a write to it is never enabled.
        stage_next.rf_enable   = EX_valid & EX_control_signals[CTRL_RF_EN]
                                 & (EX_dest != 5'd0);
        stage_next.mem_rw      = EX_control_signals[CTRL_MEM_RW];
        stage_next.mem_size    = decode_mem_size(
                                     EX_control_signals[CTRL_SIZE_HI:CTRL_SIZE_LO]);
        stage_next.load_signed = EX_control_signals[CTRL_LOAD_SIGNED];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_reg <= '0;
        end else if (flush) begin
            stage_reg <= '0;
        end else if (!stall) begin
            stage_reg <= stage_next;
        end
    end

    assign MEM_control_signals = stage_reg.ctrl;
    assign MEM_alu_out         = stage_reg.alu_out;
    assign MEM_store_data      = stage_reg.store_data;
    assign MEM_dest            = stage_reg.dest;
    assign MEM_PC8             = stage_reg.pc8;
    assign MEM_valid           = stage_reg.valid;
    assign MEM_load_instr      = stage_reg.load_instr;
    assign MEM_rf_enable       = stage_reg.rf_enable;
    assign MEM_mem_enable      = stage_reg.mem_enable;
    assign MEM_mem_rw          = stage_reg.mem_rw;
    assign MEM_mem_size        = stage_reg.mem_size;
    assign MEM_load_signed     = stage_reg.load_signed;

`ifdef EXMEM_HILO_EN
    // HI/LO only change on a genuine load of a valid instruction; flush and
    // stall both suppress the write.
    logic load_en;
    logic hi_we;
    logic lo_we;

    assign load_en = !flush && !stall;
    assign hi_we   = load_en && EX_valid && EX_control_signals[CTRL_HI_WE];
    assign lo_we   = load_en && EX_valid && EX_control_signals[CTRL_LO_WE];

    hilo_reg u_hilo_reg (
        .clk   (clk),
        .reset (reset),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (EX_alu_out),
        .hi    (MEM_hi),
        .lo    (MEM_lo)
    );
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// -----------------------------------------------------------------------------
// tb_exmem_stage
// Self-checking bench for exmem_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
// Honours EXMEM_HILO_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_exmem_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [21:0] ex_ctrl;
    logic [31:0] ex_alu;
    logic [31:0] ex_sd;
    logic [4:0]  ex_dest;
    logic [8:0]  ex_pc8;
    logic        ex_valid;

    logic [21:0] mem_ctrl;
    logic [31:0] mem_alu;
    logic [31:0] mem_sd;
    logic [4:0]  mem_dest;
    logic [8:0]  mem_pc8;
    logic        mem_valid;
    logic        mem_load;
    logic        mem_rf_en;
    logic        mem_mem_en;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_ls;
`ifdef EXMEM_HILO_EN
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
`endif

    exmem_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .flush               (flush),
        .EX_control_signals  (ex_ctrl),
        .EX_alu_out          (ex_alu),
        .EX_store_data       (ex_sd),
        .EX_dest             (ex_dest),
        .EX_PC8              (ex_pc8),
        .EX_valid            (ex_valid),
        .MEM_control_signals (mem_ctrl),
        .MEM_alu_out         (mem_alu),
        .MEM_store_data      (mem_sd),
        .MEM_dest            (mem_dest),
        .MEM_PC8             (mem_pc8),
        .MEM_valid           (mem_valid),
        .MEM_load_instr      (mem_load),
        .MEM_rf_enable       (mem_rf_en),
        .MEM_mem_enable      (mem_mem_en),
        .MEM_mem_rw          (mem_rw),
        .MEM_mem_size        (mem_size),
        .MEM_load_signed     (mem_ls)
`ifdef EXMEM_HILO_EN
       ,.MEM_hi              (mem_hi),
        .MEM_lo              (mem_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (what MEM should hold) ----------------
    logic [21:0] m_ctrl;
    logic [31:0] m_alu;
    logic [31:0] m_sd;
    logic [4:0]  m_dest;
    logic [8:0]  m_pc8;
    logic        m_valid;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic model_bubble();
        m_ctrl  = '0;
        m_alu   = '0;
        m_sd    = '0;
        m_dest  = '0;
        m_pc8   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_hi = '0;
        m_lo = '0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs presented.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (flush) begin
            model_bubble();
        end else if (!stall) begin
            m_ctrl  = ex_ctrl;
            m_alu   = ex_alu;
            m_sd    = ex_sd;
            m_dest  = ex_dest;
            m_pc8   = ex_pc8;
            m_valid = ex_valid;
            if (ex_valid && ex_ctrl[2]) m_hi = ex_alu;
            if (ex_valid && ex_ctrl[1]) m_lo = ex_alu;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] sz;
        sz = m_ctrl[19:18];
        if (sz == 2'b11) sz = 2'b10;
        check({tag, ".ctrl"},   32'(mem_ctrl),   32'(m_ctrl));
        check({tag, ".alu"},    mem_alu,         m_alu);
        check({tag, ".sd"},     mem_sd,          m_sd);
        check({tag, ".dest"},   32'(mem_dest),   32'(m_dest));
        check({tag, ".pc8"},    32'(mem_pc8),    32'(m_pc8));
        check({tag, ".valid"},  32'(mem_valid),  32'(m_valid));
        check({tag, ".load"},   32'(mem_load),   32'(m_valid & m_ctrl[10]));
        check({tag, ".rf_en"},  32'(mem_rf_en),
              32'(m_valid & m_ctrl[9] & (m_dest != 5'd0)));
        check({tag, ".mem_en"}, 32'(mem_mem_en), 32'(m_valid & m_ctrl[21]));
        check({tag, ".rw"},     32'(mem_rw),     32'(m_ctrl[20]));
        check({tag, ".size"},   32'(mem_size),   32'(sz));
        check({tag, ".ls"},     32'(mem_ls),     32'(m_ctrl[7]));
`ifdef EXMEM_HILO_EN
        check({tag, ".hi"},     mem_hi,          m_hi);
        check({tag, ".lo"},     mem_lo,          m_lo);
`endif
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    // Returns at the falling edge so the caller can drive the next inputs.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
        $display("[%0t] %s rst=%0b st=%0b fl=%0b -> valid=%0b alu=%08h rf=%0b me=%0b",
                 $time, tag, reset, stall, flush, mem_valid, mem_alu,
                 mem_rf_en, mem_mem_en);
    endtask

    task automatic drive(input logic [21:0] c, input logic [31:0] a,
                         input logic [31:0] s, input logic [4:0] d,
                         input logic [8:0] p, input logic v);
        ex_ctrl  = c;
        ex_alu   = a;
        ex_sd    = s;
        ex_dest  = d;
        ex_pc8   = p;
        ex_valid = v;
    endtask

    task automatic drive_random();
        logic [31:0] r;
        r = $urandom;
        ex_ctrl  = r[21:0];
        ex_alu   = $urandom;
        ex_sd    = $urandom;
        r = $urandom;
        ex_dest  = ($urandom_range(0, 4) == 0) ? 5'd0 : r[4:0];
        ex_pc8   = r[16:8];
        ex_valid = ($urandom_range(0, 3) != 0);
    endtask

    // Reset raised mid-cycle while a load is pending; outputs must clear
    // before any further clock edge. Held across one edge, then released.
    task automatic async_reset(input string tag);
        stall = 1'b0;
        flush = 1'b0;
        drive_random();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        $display("[%0t] %s async reset -> valid=%0b alu=%08h", $time, tag,
                 mem_valid, mem_alu);
        step({tag, ".held"});
        reset = 1'b0;
    endtask

    logic [31:0] saved_alu;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive('0, '0, '0, '0, '0, 1'b0);
        model_reset();
        #1;
        check_all("reset0");
        step("reset1");
        reset = 1'b0;

        // Basic load
        drive(22'h200200, 32'h10, 32'h55, 5'd5, 9'h44, 1'b1);
        step("load");
        check("load.alu_c",    mem_alu,           32'h10);
        check("load.mem_en_c", 32'(mem_mem_en),   32'd1);
        check("load.rf_en_c",  32'(mem_rf_en),    32'd1);
        check("load.valid_c",  32'(mem_valid),    32'd1);

        // Stall three cycles with changing inputs, then release
        saved_alu = mem_alu;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step($sformatf("stall%0d", i));
            check($sformatf("stall%0d.hold", i), mem_alu, saved_alu);
        end
        stall = 1'b0;
        drive(22'h0C0680, 32'hCAFE0001, 32'h1234, 5'd9, 9'h1F0, 1'b1);
        step("unstall");
        check("unstall.alu_c", mem_alu, 32'hCAFE0001);
        check("unstall.size_c", 32'(mem_size), 32'd2);

        // Flush together with stall
        stall = 1'b1;
        flush = 1'b1;
        drive(22'h3FFFFF, 32'hFFFF_FFFF, 32'h1, 5'd7, 9'h1, 1'b1);
        step("flush_stall");
        check("flush_stall.valid_c", 32'(mem_valid), 32'd0);
        check("flush_stall.ctrl_c",  32'(mem_ctrl),  32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // r0 write suppression, invalid instruction suppression
        drive(22'h000200, 32'h77, 32'h0, 5'd0, 9'h0, 1'b1);
        step("r0");
        check("r0.rf_en_c", 32'(mem_rf_en), 32'd0);
        drive(22'h3FFFFF, 32'h88, 32'h0, 5'd3, 9'h0, 1'b0);
        step("invalid");
        check("invalid.mem_en_c", 32'(mem_mem_en), 32'd0);
        check("invalid.size_c",   32'(mem_size),   32'd2);

        // Async reset in the middle of a load
        drive(22'h200200, 32'h10, 32'h55, 5'd5, 9'h44, 1'b1);
        step("preload");
        async_reset("rst_mid");
        drive(22'h000200, 32'h99, 32'h0, 5'd4, 9'h2, 1'b1);
        step("resume");

`ifdef EXMEM_HILO_EN
        drive(22'h000004, 32'hDEADBEEF, 32'h0, 5'd0, 9'h0, 1'b1);
        step("hi_wr");
        check("hi_wr.hi_c", mem_hi, 32'hDEADBEEF);
        check("hi_wr.lo_c", mem_lo, 32'h0);
        flush = 1'b1;
        drive(22'h000006, 32'h12345678, 32'h0, 5'd0, 9'h0, 1'b1);
        step("hi_flush");
        check("hi_flush.hi_c", mem_hi, 32'hDEADBEEF);
        flush = 1'b0;
`endif

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset($sformatf("rnd%0d", i));
            end else begin
                stall = ($urandom_range(0, 3) == 0);
                flush = ($urandom_range(0, 7) == 0);
                drive_random();
                step($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: hold every register at its current value.
REQ-004 SHALL have port flush, input, 1 bit: load a bubble on the next edge.
REQ-005 SHALL have port EX_control_signals, input, 22 bits: control word from the EX stage, same bit map as the ID/EX control word.
REQ-006 SHALL have port EX_alu_out, input, 32 bits: ALU result or effective address.
REQ-007 SHALL have port EX_store_data, input, 32 bits: store data, taken from the forwarded PB operand.
REQ-008 SHALL have port EX_dest, input, 5 bits: selected destination register (rd, rt or r31).
REQ-009 SHALL have port EX_PC8, input, 9 bits: return address for link instructions.
REQ-010 SHALL have port EX_valid, input, 1 bit: 1 means EX holds a real instruction.
REQ-011 SHALL have outputs MEM_control_signals (22 bits), MEM_alu_out (32), MEM_store_data (32), MEM_dest (5), MEM_PC8 (9) and MEM_valid (1): registered copies of the inputs.
REQ-012 SHALL have decoded registered outputs MEM_load_instr (ctrl[10]), MEM_rf_enable (ctrl[9]), MEM_mem_enable (ctrl[21]), MEM_mem_rw (ctrl[20], 1 = write), MEM_mem_size (ctrl[19:18]: 00 byte, 01 half, 10 word) and MEM_load_signed (ctrl[7]).
REQ-013 SHALL have outputs MEM_hi and MEM_lo, 32 bits each, present only under EXMEM_HILO_EN.

Function
REQ-014 SHALL update all registers on the clk rising edge with priority reset > flush > stall > load.
REQ-015 SHALL, on load, capture all inputs with one-cycle latency and drive decoded outputs from the same captured control word.
REQ-016 SHALL, on flush (with or without stall), write a bubble: MEM_valid=0, control word and all decoded outputs 0, data fields 0.
REQ-017 SHALL, on stall without flush, hold every output unchanged, including MEM_valid.
REQ-018 SHALL, when EX_valid=0 on load, force MEM_rf_enable, MEM_mem_enable and MEM_load_instr to 0 regardless of control bits.
REQ-019 SHALL force MEM_rf_enable to 0 whenever the captured EX_dest is 0 (no writes to r0).
REQ-020 SHALL map the reserved mem_size code 11 to word (10) on MEM_mem_size.

Reset
REQ-021 SHALL, while reset=1, immediately drive every output to 0, including MEM_valid and, when compiled in, HI/LO; the reset acts mid-stall or mid-flush.
REQ-022 SHALL resume normal loading on the first rising edge after reset deasserts.

Configuration
REQ-023 SHALL honour the macro EXMEM_HILO_EN: when defined, HI and LO 32-bit registers are written from EX_alu_out when EX_valid=1, on load, with ctrl[2] (HI) or ctrl[1] (LO) set; flush and stall block the write; both set writes both.
REQ-024 SHALL, without EXMEM_HILO_EN, omit MEM_hi, MEM_lo and the HI/LO registers, leaving ctrl[2:1] only passed through.

Structure
REQ-025 SHALL take control-bit index constants (ctrl indices 21..18, 10, 9, 7, 2, 1) and mem_size encodings from the shared pipeline package, also used by the ID/EX register.
REQ-026 SHALL implement HI/LO as one sub-module, hilo_reg, instantiated only under EXMEM_HILO_EN.

Verification
REQ-027 SHALL cover load: ctrl=0x200200 (mem_en, rf_en), alu_out=0x00000010, dest=5, valid=1 -> next cycle MEM_alu_out=0x10, MEM_mem_enable=1, MEM_rf_enable=1, MEM_valid=1.
REQ-028 SHALL cover stall: hold stall=1 for 3 cycles with changing inputs -> outputs stay at their pre-stall values, then load the current inputs on the first cycle after stall drops.
REQ-029 SHALL cover flush with stall: flush=1 and stall=1 together -> next cycle MEM_valid=0 and all control outputs 0.
REQ-030 SHALL cover r0 write suppression: dest=0 with rf_en=1 -> MEM_rf_enable=0; a case with EX_valid=0 and ctrl=0x3FFFFF -> MEM_mem_enable=0.
REQ-031 SHALL cover async reset asserted mid-cycle during a load -> all outputs 0 before the next edge.
REQ-032 SHALL, with EXMEM_HILO_EN defined, cover ctrl[2]=1 and alu_out=0xDEADBEEF -> MEM_hi=0xDEADBEEF with MEM_lo unchanged; the same stimulus with flush=1 leaves MEM_hi unchanged.
